fifo_ctrl_32kx4: RTL and testbench



---
 rtl/fifo_ctrl_32kx4.sv | 106 ++++++++++
 tb/tb_fifo_ctrl_32kx4.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_32kx4.sv
// 32768-deep x 4-bit synchronous FIFO controller wrapped around an external
// dual-port synchronous-read RAM: port 1 writes, port 2 reads.
module fifo_ctrl_32kx4 #(
    parameter int unsigned AF_LEVEL = 32000,
    parameter int unsigned AE_LEVEL = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_data,
    input  logic        rd_en,
    output logic [3:0]  rd_data,
    output logic        rd_valid,
    output logic        full,
    output logic        empty,
    output logic        almost_full,
    output logic        almost_empty,
    output logic [15:0] count,
    output logic        overflow,
    output logic        underflow,
    output logic        ram_rw_1,
    output logic [14:0] ram_address_1,
    output logic [3:0]  ram_data_in_1,
    output logic        ram_rw_2,
    output logic [14:0] ram_address_2,
    output logic [3:0]  ram_data_in_2,
    input  logic [3:0]  ram_data_out_2
);

    localparam logic [15:0] DEPTH  = 16'd32768;
    localparam logic [15:0] AF_THR = 16'(AF_LEVEL);
    localparam logic [15:0] AE_THR = 16'(AE_LEVEL);

    logic [14:0] wr_ptr_reg;
    logic [14:0] rd_ptr_reg;
    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic        full_reg;
    logic        empty_reg;
    logic        af_reg;
    logic        ae_reg;
    logic        overflow_reg;
    logic        underflow_reg;
    logic [1:0]  rv_pipe_reg;
    logic        push_ok;
    logic        pop_ok;

    always_comb begin
        push_ok    = wr_en & ~full_reg;
        pop_ok     = rd_en & ~empty_reg;
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 16'd1;
            2'b01:   count_next = count_reg - 16'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rv_pipe_reg   <= 2'b00;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 15'd1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 15'd1;
            count_reg     <= count_next;
            full_reg      <= (count_next == DEPTH);
            empty_reg     <= (count_next == 16'd0);
            af_reg        <= (count_next >= AF_THR);
            ae_reg        <= (count_next <= AE_THR);
            overflow_reg  <= wr_en & full_reg;
            underflow_reg <= rd_en & empty_reg;
            // RAM registers the address on the pop edge and updates its output one edge later
            rv_pipe_reg   <= {rv_pipe_reg[0], pop_ok};
        end
    end

    // When idle, point port 1 at ~rd_ptr so it can never alias the read address.
    assign ram_rw_1      = push_ok & ~rst;
    assign ram_address_1 = ram_rw_1 ? wr_ptr_reg : ~rd_ptr_reg;
    assign ram_data_in_1 = wr_data;
    assign ram_rw_2      = 1'b0;
    assign ram_address_2 = rd_ptr_reg;
    assign ram_data_in_2 = 4'd0;

    assign rd_data      = ram_data_out_2;
    assign rd_valid     = rv_pipe_reg[1];
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl_32kx4.sv
// Directed bench for fifo_ctrl_32kx4 with a behavioural 32K x 4 RAM and a
// queue-based reference of the FIFO contents, occupancy and flags.
module tb_fifo_ctrl_32kx4;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic        rd_en;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [15:0] count;
    logic        overflow;
    logic        underflow;
    logic        ram_rw_1;
    logic [14:0] ram_address_1;
    logic [3:0]  ram_data_in_1;
    logic        ram_rw_2;
    logic [14:0] ram_address_2;
    logic [3:0]  ram_data_in_2;
    logic [3:0]  ram_data_out_2;

    fifo_ctrl_32kx4 #(.AF_LEVEL(32000), .AE_LEVEL(16)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_rw_1(ram_rw_1), .ram_address_1(ram_address_1), .ram_data_in_1(ram_data_in_1),
        .ram_rw_2(ram_rw_2), .ram_address_2(ram_address_2), .ram_data_in_2(ram_data_in_2),
        .ram_data_out_2(ram_data_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM: address registered on one edge, data out on the next.
    logic [3:0]  mem [0:32767];
    logic [14:0] addr2_reg;
    logic [3:0]  dout_reg;
    int          collisions;
    initial collisions = 0;
    always @(posedge clk) begin
        if (ram_rw_1)
            mem[ram_address_1] <= ram_data_in_1;
        if (ram_rw_1 == ram_rw_2 && ram_address_1 == ram_address_2)
            collisions <= collisions + 1;
        addr2_reg <= ram_address_2;
        dout_reg  <= mem[addr2_reg];
    end
    assign ram_data_out_2 = dout_reg;

    int          n_assert;
    int          n_fail;
    logic [3:0]  q [$];
    logic [14:0] m_wr;
    logic [14:0] m_rd;
    logic        v1, v2;
    logic [3:0]  d1, d2;
    logic        m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == 32768));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 32000));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 16));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(v2));
        if (v2)
            chk("rd_data", 32'(rd_data), 32'(d2));
    endtask

    // One clock: drive inputs, check RAM drive, clock, update reference, check outputs.
    task automatic cycle(input logic wr, input logic [3:0] wd, input logic rd);
        logic        was_full, was_empty, push, pop;
        logic [14:0] exp_a1;
        wr_en = wr; wr_data = wd; rd_en = rd;
        #1;
        was_full  = (q.size() == 32768);
        was_empty = (q.size() == 0);
        push = wr && !was_full;
        pop  = rd && !was_empty;
        exp_a1 = push ? m_wr : ~m_rd;
        chk("ram_rw_1", 32'(ram_rw_1), 32'(push));
        chk("ram_address_1", 32'(ram_address_1), 32'(exp_a1));
        chk("ram_address_2", 32'(ram_address_2), 32'(m_rd));
        if (push)
            chk("ram_data_in_1", 32'(ram_data_in_1), 32'(wd));
        @(posedge clk);
        #1;
        v2 = v1; d2 = d1;
        v1 = pop;
        if (pop) begin
            d1 = q.pop_front();
            m_rd = m_rd + 15'd1;
        end
        if (push) begin
            q.push_back(wd);
            m_wr = m_wr + 15'd1;
        end
        m_ovf = wr && was_full;
        m_unf = rd && was_empty;
        check_outputs();
        $display("t=%0t wr=%0b wd=%h rd=%0b -> count=%0d rd_valid=%0b rd_data=%h ovf=%0b unf=%0b",
                 $time, wr, wd, rd, count, rd_valid, rd_data, overflow, underflow);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b1; wr_data = 4'hF; rd_en = 1'b0;
        #1;
        chk("ram_rw_1 in reset", 32'(ram_rw_1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        q.delete();
        m_wr = '0; m_rd = '0;
        v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        check_outputs();
        $display("t=%0t reset -> count=%0d empty=%0b rd_valid=%0b", $time, count, empty, rd_valid);
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        repeat (2) cycle(1'b0, 4'h0, 1'b0);

        // push 3, A, 5 then pop three in a row
        cycle(1'b1, 4'h3, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'h5, 1'b0);
        repeat (3) cycle(1'b0, 4'h0, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b0);
        chk("count after 3/3", 32'(count), 32'd0);
        chk("empty after 3/3", 32'(empty), 32'd1);

        // pop on empty, then simultaneous push/pop on empty
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'h7, 1'b1);
        chk("count after push/pop on empty", 32'(count), 32'd1);
        cycle(1'b0, 4'h0, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b0);

        // steady state at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 4'(i), 1'b1);
        chk("count steady", 32'(count), 32'd5);
        repeat (5) cycle(1'b0, 4'h0, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b0);

        // reset one cycle after a pop is accepted with count 10
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i + 6), 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        do_reset();
        repeat (3) cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'h9, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b0);

        // fill to full across the pointer wrap, overflow, idle, full-with-pop, drain
        for (int i = 0; i < 32768; i++) cycle(1'b1, 4'(i), 1'b0);
        chk("count full", 32'(count), 32'd32768);
        cycle(1'b1, 4'hE, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'hD, 1'b1);
        chk("count after blocked push with pop", 32'(count), 32'd32767);
        for (int i = 0; i < 32767; i++) cycle(1'b0, 4'h0, 1'b1);
        repeat (3) cycle(1'b0, 4'h0, 1'b0);
        chk("count drained", 32'(count), 32'd0);
        chk("port collisions", 32'(collisions), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
